// File: rtl/a2mem_softswitch_tracker.sv
// Apple II soft-switch tracker: snoops strobed bus cycles, keeps video/annunciator/IIe aux
// switch state and the keyboard latch. Optional change-event FIFO under A2_SW_EVENT_FIFO_EN.
module a2mem_softswitch_tracker #(
    parameter int unsigned NUM_AN       = 4,
    parameter bit          IIE_SWITCHES = 1'b1,
    parameter bit          RESET_TEXT   = 1'b1,
    parameter int unsigned EVT_DEPTH    = 8
) (
    input  logic        clk_logic,
    input  logic        system_reset_n,
    input  logic        bus_strobe_i,
    input  logic [15:0] bus_addr_i,
    input  logic        bus_rw_n_i,
    input  logic [6:0]  key_data_i,
    input  logic        key_valid_i,
    output logic [12:0] sw_o,
    output logic [3:0]  an_o,
    output logic [7:0]  keycode_o,
    output logic [5:0]  evt_data_o,
    output logic        evt_valid_o,
    input  logic        evt_ready_i,
    output logic        evt_overflow_o,
    input  logic        evt_ovf_clr_i
);

    localparam int unsigned SW_W      = 13;
    localparam int unsigned AN_W      = 4;
    localparam int unsigned ST_W      = SW_W + AN_W;
    localparam int unsigned IDX_W     = 5;
    localparam int unsigned EVT_W     = IDX_W + 1;
    localparam int unsigned KEY_W     = 7;
    localparam int unsigned SLOTC3_B  = 10;
    localparam int unsigned AW        = $clog2(EVT_DEPTH);
    localparam int unsigned CW        = AW + 1;
    localparam logic [ST_W-1:0] ST_RESET = {{(ST_W-2){1'b0}}, RESET_TEXT, 1'b0};

    // Switch and annunciator state share one vector: bit position == event index
    logic [ST_W-1:0]  state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             strobe_q, strobe_d;

    logic             upd_vld;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_val;
    logic             key_clr;
    logic             evt_push;
    logic [3:0]       lo;

    assign lo = bus_addr_i[3:0];

    // Address decode: at most one switch update per strobe
    always_comb begin
        upd_vld = 1'b0;
        upd_idx = '0;
        upd_val = 1'b0;
        key_clr = 1'b0;
        if (bus_strobe_i) begin
            if (bus_addr_i[15:4] == 12'hC05) begin
                if (!lo[3]) begin
                    upd_vld = 1'b1;
                    upd_idx = IDX_W'(1) + IDX_W'(lo[2:1]);
                    upd_val = lo[0];
                end else if (32'(lo[2:1]) < NUM_AN) begin
                    upd_vld = 1'b1;
                    upd_idx = IDX_W'(SW_W) + IDX_W'(lo[2:1]);
                    upd_val = lo[0];
                end
            end else if (bus_addr_i[15:4] == 12'hC00) begin
                if (IIE_SWITCHES && !bus_rw_n_i) begin
                    upd_vld = 1'b1;
                    upd_idx = IDX_W'(5) + IDX_W'(lo[3:1]);
                    upd_val = lo[0];
                end
            end else if (bus_addr_i[15:8] == 8'hC3) begin
                if (!state_q[SLOTC3_B]) begin
                    upd_vld = 1'b1;
                    upd_idx = '0;
                    upd_val = 1'b1;
                end
            end else if (bus_addr_i == 16'hCFFF) begin
                upd_vld = 1'b1;
                upd_idx = '0;
                upd_val = 1'b0;
            end
            if ((bus_addr_i == 16'hC010) ||
                ((bus_addr_i[15:4] == 12'hC01) && bus_rw_n_i)) begin
                key_clr = 1'b1;
            end
        end
    end

    assign evt_push = upd_vld && (state_q[upd_idx] != upd_val);

    always_comb begin
        state_d = state_q;
        if (upd_vld) begin
            state_d[upd_idx] = upd_val;
        end
    end

    // A new key outranks a same-cycle strobe clear
    always_comb begin
        key_d    = key_q;
        strobe_d = strobe_q;
        if (key_valid_i) begin
            key_d    = key_data_i;
            strobe_d = 1'b1;
        end else if (key_clr) begin
            strobe_d = 1'b0;
        end
    end

    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state_q  <= ST_RESET;
            key_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            strobe_q <= strobe_d;
        end
    end

    assign sw_o      = state_q[SW_W-1:0];
    assign an_o      = state_q[ST_W-1:SW_W];
    assign keycode_o = {strobe_q, key_q};

`ifdef A2_SW_EVENT_FIFO_EN
    logic [EVT_W-1:0] mem_q [EVT_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             full;
    logic             pop;
    logic             wr_en;

    assign full  = (cnt_q == CW'(EVT_DEPTH));
    assign pop   = valid_q && evt_ready_i;
    // A pop frees the head slot in the same edge, so a full FIFO still accepts
    assign wr_en = evt_push && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_en && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!wr_en && pop) begin
            cnt_d = cnt_q - CW'(1);
        end
        if (evt_push && full && !pop) begin
            ovf_d = 1'b1;
        end else if (evt_ovf_clr_i) begin
            ovf_d = 1'b0;
        end
        valid_d = (cnt_d != '0);
    end

    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk_logic) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {upd_val, upd_idx};
        end
    end

    assign evt_valid_o    = valid_q;
    assign evt_data_o     = valid_q ? mem_q[rd_ptr_q] : '0;
    assign evt_overflow_o = ovf_q;
`else
    logic unused_evt_inputs;

    assign unused_evt_inputs = ^{evt_ready_i, evt_ovf_clr_i, evt_push};
    assign evt_valid_o       = 1'b0;
    assign evt_data_o        = '0;
    assign evt_overflow_o    = 1'b0;
`endif

endmodule

// File: tb/tb_a2mem_softswitch_tracker.sv
// Bench for a2mem_softswitch_tracker: two configurations driven in parallel, checked every
// cycle against a behavioural model; event checks follow A2_SW_EVENT_FIFO_EN.
module tb_a2mem_softswitch_tracker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_strobe_i = 1'b0;
    logic [15:0] bus_addr_i = '0;
    logic        bus_rw_n_i = 1'b1;
    logic [6:0]  key_data_i = '0;
    logic        key_valid_i = 1'b0;
    logic        evt_ready_i = 1'b1;
    logic        evt_ovf_clr_i = 1'b0;

    logic [12:0] sw_a, sw_b;
    logic [3:0]  an_a, an_b;
    logic [7:0]  kc_a, kc_b;
    logic [5:0]  ed_a, ed_b;
    logic        ev_a, ev_b, ov_a, ov_b;

    always #5 clk = ~clk;

    a2mem_softswitch_tracker #(
        .NUM_AN(4), .IIE_SWITCHES(1'b1), .RESET_TEXT(1'b1), .EVT_DEPTH(8)
    ) u_dut_a (
        .clk_logic(clk), .system_reset_n(rst_n), .bus_strobe_i(bus_strobe_i),
        .bus_addr_i(bus_addr_i), .bus_rw_n_i(bus_rw_n_i), .key_data_i(key_data_i),
        .key_valid_i(key_valid_i), .sw_o(sw_a), .an_o(an_a), .keycode_o(kc_a),
        .evt_data_o(ed_a), .evt_valid_o(ev_a), .evt_ready_i(evt_ready_i),
        .evt_overflow_o(ov_a), .evt_ovf_clr_i(evt_ovf_clr_i)
    );

    a2mem_softswitch_tracker #(
        .NUM_AN(2), .IIE_SWITCHES(1'b0), .RESET_TEXT(1'b0), .EVT_DEPTH(4)
    ) u_dut_b (
        .clk_logic(clk), .system_reset_n(rst_n), .bus_strobe_i(bus_strobe_i),
        .bus_addr_i(bus_addr_i), .bus_rw_n_i(bus_rw_n_i), .key_data_i(key_data_i),
        .key_valid_i(key_valid_i), .sw_o(sw_b), .an_o(an_b), .keycode_o(kc_b),
        .evt_data_o(ed_b), .evt_valid_o(ev_b), .evt_ready_i(evt_ready_i),
        .evt_overflow_o(ov_b), .evt_ovf_clr_i(evt_ovf_clr_i)
    );

    // Model configuration per instance
    int num_an [2] = '{4, 2};
    bit iie    [2] = '{1'b1, 1'b0};
    bit rtext  [2] = '{1'b1, 1'b0};
    int depth  [2] = '{8, 4};

    bit         sw_m  [2][13];
    bit         an_m  [2][4];
    bit         ovf_m [2];
    logic [5:0] fq    [2][16];
    int         fcnt  [2];
    logic [6:0] key_m;
    bit         strobe_m;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 13; j++) sw_m[k][j] = 1'b0;
            sw_m[k][1] = rtext[k];
            for (int j = 0; j < 4; j++) an_m[k][j] = 1'b0;
            ovf_m[k] = 1'b0;
            fcnt[k]  = 0;
        end
        key_m    = '0;
        strobe_m = 1'b0;
    endtask

    // Which switch (if any) a strobed access targets, from the address map
    task automatic model_bus(int k, int a, bit rw, output bit hit, output int idx, output bit val);
        hit = 1'b0; idx = 0; val = 1'b0;
        if (a >= 'hC050 && a <= 'hC057) begin
            hit = 1'b1; idx = 1 + (a - 'hC050) / 2; val = a[0];
        end else if (a >= 'hC058 && a <= 'hC05F) begin
            if ((a - 'hC058) / 2 < num_an[k]) begin
                hit = 1'b1; idx = 13 + (a - 'hC058) / 2; val = a[0];
            end
        end else if (a >= 'hC000 && a <= 'hC00F) begin
            if (iie[k] && !rw) begin
                hit = 1'b1; idx = 5 + (a - 'hC000) / 2; val = a[0];
            end
        end else if (a >= 'hC300 && a <= 'hC3FF) begin
            if (!sw_m[k][10]) begin
                hit = 1'b1; idx = 0; val = 1'b1;
            end
        end else if (a == 'hCFFF) begin
            hit = 1'b1; idx = 0; val = 1'b0;
        end
    endtask

    task automatic compare_all(string ph);
        logic [12:0] es;
        logic [3:0]  ea;
        logic        ev;
        logic [5:0]  ed;
        logic        eo;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 13; j++) es[j] = sw_m[k][j];
            for (int j = 0; j < 4; j++) ea[j] = an_m[k][j];
`ifdef A2_SW_EVENT_FIFO_EN
            ev = (fcnt[k] > 0);
            ed = ev ? fq[k][0] : 6'd0;
            eo = ovf_m[k];
`else
            ev = 1'b0; ed = 6'd0; eo = 1'b0;
`endif
            if (k == 0) begin
                check({ph, " sw_a"}, 32'(sw_a), 32'(es));
                check({ph, " an_a"}, 32'(an_a), 32'(ea));
                check({ph, " kc_a"}, 32'(kc_a), 32'({strobe_m, key_m}));
                check({ph, " evv_a"}, 32'(ev_a), 32'(ev));
                check({ph, " evd_a"}, 32'(ed_a), 32'(ed));
                check({ph, " ovf_a"}, 32'(ov_a), 32'(eo));
            end else begin
                check({ph, " sw_b"}, 32'(sw_b), 32'(es));
                check({ph, " an_b"}, 32'(an_b), 32'(ea));
                check({ph, " kc_b"}, 32'(kc_b), 32'({strobe_m, key_m}));
                check({ph, " evv_b"}, 32'(ev_b), 32'(ev));
                check({ph, " evd_b"}, 32'(ed_b), 32'(ed));
                check({ph, " ovf_b"}, 32'(ov_b), 32'(eo));
            end
        end
    endtask

    // One clock: drive at negedge, advance the model, compare 1 time unit after posedge
    task automatic step(string ph, bit stb, logic [15:0] a, bit rw, bit kv, logic [6:0] kd,
                        bit rdy, bit clr);
        bit hit, val, cur, ovset;
        int idx;
        @(negedge clk);
        bus_strobe_i  = stb;
        bus_addr_i    = a;
        bus_rw_n_i    = rw;
        key_valid_i   = kv;
        key_data_i    = kd;
        evt_ready_i   = rdy;
        evt_ovf_clr_i = clr;
        for (int k = 0; k < 2; k++) begin
            hit = 1'b0; idx = 0; val = 1'b0; ovset = 1'b0;
            if (stb) model_bus(k, int'(a), rw, hit, idx, val);
            if (hit) begin
                cur = (idx < 13) ? sw_m[k][idx] : an_m[k][idx-13];
                if (idx < 13) sw_m[k][idx] = val; else an_m[k][idx-13] = val;
                if (cur == val) hit = 1'b0;
            end
            if (fcnt[k] > 0 && rdy) begin
                for (int j = 0; j < 15; j++) fq[k][j] = fq[k][j+1];
                fcnt[k]--;
            end
            if (hit) begin
                if (fcnt[k] < depth[k]) begin
                    fq[k][fcnt[k]] = {val, 5'(idx)};
                    fcnt[k]++;
                end else begin
                    ovset = 1'b1;
                end
            end
            if (ovset) ovf_m[k] = 1'b1;
            else if (clr) ovf_m[k] = 1'b0;
        end
        if (kv) begin
            key_m = kd; strobe_m = 1'b1;
        end else if (stb && (a == 16'hC010 || (a >= 16'hC011 && a <= 16'hC01F && rw))) begin
            strobe_m = 1'b0;
        end
        @(posedge clk);
        #1;
        compare_all(ph);
    endtask

    task automatic idle(string ph, int n);
        for (int i = 0; i < n; i++) step(ph, 1'b0, 16'h0000, 1'b1, 1'b0, 7'h00, 1'b1, 1'b0);
    endtask

    initial begin
        logic [15:0] ra;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all("reset");
        rst_n = 1'b1;

        // TEXT set while already set, then clear
        step("t1", 1'b1, 16'hC051, 1'b1, 1'b0, 7'h00, 1'b1, 1'b0);
        check("t1 text_hold", 32'(sw_a[1]), 32'd1);
        step("t1", 1'b1, 16'hC050, 1'b1, 1'b0, 7'h00, 1'b1, 1'b0);
        check("t1 text_clr", 32'(sw_a[1]), 32'd0);
`ifdef A2_SW_EVENT_FIFO_EN
        check("t1 evt", 32'(ed_a), 32'h01);
`endif
        idle("t1", 3);

        // RAMWRT via write, read of the clear address ignored
        step("t2", 1'b1, 16'hC005, 1'b0, 1'b0, 7'h00, 1'b1, 1'b0);
        step("t2", 1'b1, 16'hC004, 1'b1, 1'b0, 7'h00, 1'b1, 1'b0);
        check("t2 ramwrt_a", 32'(sw_a[7]), 32'd1);
        check("t2 ramwrt_b", 32'(sw_b[7]), 32'd0);
        idle("t2", 3);

        // Annunciators beyond NUM_AN
        step("t3", 1'b1, 16'hC05B, 1'b1, 1'b0, 7'h00, 1'b1, 1'b0);
        step("t3", 1'b1, 16'hC05D, 1'b1, 1'b0, 7'h00, 1'b1, 1'b0);
        check("t3 an_b", 32'(an_b), 32'h2);
        check("t3 an_a", 32'(an_a), 32'h6);
        idle("t3", 3);

        // Keyboard latch priority
        step("t4", 1'b0, 16'h0000, 1'b1, 1'b1, 7'h41, 1'b1, 1'b0);
        check("t4 key41", 32'(kc_a), 32'hC1);
        step("t4", 1'b1, 16'hC010, 1'b1, 1'b1, 7'h42, 1'b1, 1'b0);
        check("t4 key42", 32'(kc_a), 32'hC2);
        step("t4", 1'b1, 16'hC010, 1'b1, 1'b0, 7'h00, 1'b1, 1'b0);
        check("t4 keyclr", 32'(kc_a), 32'h42);

        // INTC8ROM set/clear and SLOTC3ROM gating
        step("t5", 1'b1, 16'hC300, 1'b1, 1'b0, 7'h00, 1'b1, 1'b0);
        check("t5 c8_set", 32'(sw_a[0]), 32'd1);
        step("t5", 1'b1, 16'hCFFF, 1'b1, 1'b0, 7'h00, 1'b1, 1'b0);
        check("t5 c8_clr", 32'(sw_a[0]), 32'd0);
        step("t5", 1'b1, 16'hC00B, 1'b0, 1'b0, 7'h00, 1'b1, 1'b0);
        step("t5", 1'b1, 16'hC300, 1'b1, 1'b0, 7'h00, 1'b1, 1'b0);
        check("t5 c8_gated", 32'(sw_a[0]), 32'd0);
        idle("t5", 10);

        // Overflow: nine toggles with consumer stalled, then drain and clear
        for (int i = 0; i < 9; i++)
            step("t6", 1'b1, (i % 2 == 0) ? 16'hC051 : 16'hC050, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0);
`ifdef A2_SW_EVENT_FIFO_EN
        check("t6 ovf", 32'(ov_a), 32'd1);
`endif
        idle("t6", 10);
        step("t6", 1'b0, 16'h0000, 1'b1, 1'b0, 7'h00, 1'b1, 1'b1);
        check("t6 ovf_clr", 32'(ov_a), 32'd0);

        // Random traffic with a mid-run asynchronous reset
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 5))
                0:       ra = 16'hC000 + 16'($urandom_range(0, 31));
                1:       ra = 16'hC050 + 16'($urandom_range(0, 15));
                2:       ra = 16'hC300 + 16'($urandom_range(0, 255));
                3:       ra = 16'hCFFF;
                4:       ra = 16'hC010;
                default: ra = 16'($urandom);
            endcase
            step("rnd", $urandom_range(0, 3) != 0, ra, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 7) == 0, 7'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0);
            if (i == 1500) begin
                #2;
                rst_n = 1'b0;
                #1;
                model_reset();
                compare_all("midrst");
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
